// File: rtl/ecc_scrubber_if.sv
// Memory-port bundle between the ECC scrubber and the shared data memory.
// Also carries the CPU arbitration and write-snoop signals.
interface ecc_scrubber_if #(
    parameter int ADDR_W = 8
);
    logic              cpu_busy;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_waddr;
    logic              mem_rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [38:0]       mem_wdata;
    logic [38:0]       mem_rdata;

    modport master (
        input  cpu_busy, cpu_we, cpu_waddr, mem_rdata,
        output mem_rd_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_busy, cpu_we, cpu_waddr, mem_rdata,
        input  mem_rd_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ecc_scrubber.sv
// Background SECDED scrubber: reads every word, writes back single-bit fixes, logs double-bit errors.
// Define SCRUB_CONTINUOUS_EN to restart a new pass automatically after each one completes.
module ecc_scrubber #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    ecc_scrubber_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic              uncorr_flag,
    output logic [ADDR_W-1:0] uncorr_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [38:0]       rdata_q;
    logic [38:0]       wdata_q;
    logic              cancel_q;

    function automatic logic [5:0] syndrome(input logic [38:0] cw);
        logic [5:0] s;
        s = '0;
        for (int i = 1; i < 39; i++) begin
            if (cw[i]) s ^= 6'(i);
        end
        return s;
    endfunction

    logic [5:0]  syn;
    logic        par;
    logic        is_uncorr;
    logic [38:0] corrected;
    logic        snoop_hit;
    logic        last_addr;

    // Syndrome 0 with bad parity selects bit 0, so one shift covers every correctable case.
    assign syn       = syndrome(rdata_q);
    assign par       = ^rdata_q;
    assign is_uncorr = (par && syn > 6'd38) || (!par && syn != 6'd0);
    assign corrected = rdata_q ^ (39'd1 << syn);
    assign snoop_hit = bus.cpu_we && (bus.cpu_waddr == addr);
    assign last_addr = (addr == ADDR_W'(DEPTH - 1));

    // NOTE: the strobes are decoded from the state register and gated by cpu_busy in the
    // same cycle; a registered strobe could not yield to the CPU without a cycle of lag.
    assign bus.mem_rd_en = (state == S_READ) && !bus.cpu_busy;
    assign bus.mem_we    = (state == S_WRITE) && !bus.cpu_busy && !cancel_q && !snoop_hit;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata_q;

    // NOTE: the data registers are reset along with the control state so that every
    // output, including mem_wdata, reads 0 during and right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            cancel_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            corr_cnt    <= '0;
            uncorr_cnt  <= '0;
            uncorr_flag <= 1'b0;
            uncorr_addr <= '0;
        end else begin
            done <= 1'b0;

            if (snoop_hit && ((state == S_READ && !bus.cpu_busy) || state == S_WAIT ||
                              state == S_CHECK || state == S_WRITE)) begin
                cancel_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_READ;
                        busy     <= 1'b1;
                        addr     <= '0;
                        cancel_q <= 1'b0;
                    end
                end
                S_READ: begin
                    if (!bus.cpu_busy) state <= S_WAIT;
                end
                S_WAIT: begin
                    rdata_q <= bus.mem_rdata;
                    state   <= S_CHECK;
                end
                S_CHECK: begin
                    wdata_q <= corrected;
                    if (is_uncorr) begin
                        uncorr_cnt  <= (&uncorr_cnt) ? uncorr_cnt : uncorr_cnt + 1'b1;
                        uncorr_flag <= 1'b1;
                        uncorr_addr <= addr;
                        state       <= S_NEXT;
                    end else if (par) begin
                        state <= S_WRITE;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    if (!bus.cpu_busy) begin
                        if (!cancel_q && !snoop_hit) begin
                            corr_cnt <= (&corr_cnt) ? corr_cnt : corr_cnt + 1'b1;
                        end
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    cancel_q <= 1'b0;
                    if (last_addr) begin
                        done <= 1'b1;
`ifdef SCRUB_CONTINUOUS_EN
                        // The DONE cycle is folded into the wrap so passes repeat back to back.
                        state <= S_READ;
                        addr  <= '0;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber: memory model, write scoreboard and latency checks.
module tb_ecc_scrubber;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;
    logic              uncorr_flag;
    logic [ADDR_W-1:0] uncorr_addr;

    ecc_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

    ecc_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .uncorr_flag(uncorr_flag),
        .uncorr_addr(uncorr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [38:0] mem [0:255];
    logic [38:0] golden [0:DEPTH-1];
    logic [ADDR_W+38:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data fills non-power-of-two positions, then check bits, then overall parity.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] cw;
        int k;
        logic p;
        cw = '0;
        k = 0;
        for (int pos = 1; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 6; j++) begin
            p = 1'b0;
            for (int pos = 1; pos < 39; pos++) begin
                if ((pos & (1 << j)) != 0) p ^= cw[pos];
            end
            cw[1 << j] = p;
        end
        cw[0] = ^cw[38:1];
        return cw;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we)    mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Bus monitor: arbitration rules every cycle, writebacks against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_we_exclusive", 64'(bus.mem_rd_en & bus.mem_we), 64'd0);
            if (bus.cpu_busy) check("idle_when_cpu_busy", 64'({bus.mem_rd_en, bus.mem_we}), 64'd0);
            if (bus.mem_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write_addr", 64'(bus.mem_addr), 64'hFFFF);
                end else begin
                    logic [ADDR_W+38:0] e;
                    e = sb.pop_front();
                    check("wb_addr", 64'(bus.mem_addr), 64'(e[ADDR_W+38:39]));
                    check("wb_data", 64'(bus.mem_wdata), 64'(e[38:0]));
                end
            end
        end
    end

    task automatic run_pass(input int busy_from, input int busy_len, input int we_at, output int lat);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            bus.cpu_busy  = (lat >= busy_from) && (lat < busy_from + busy_len);
            bus.cpu_we    = (lat == we_at);
            bus.cpu_waddr = 8'd3;
            start         = (lat == 6);
            if (lat == 1) check("busy_in_pass", 64'(busy), 64'd1);
            if (done) break;
        end
        check("done_seen", 64'(done), 64'd1);
        bus.cpu_busy = 1'b0;
        bus.cpu_we   = 1'b0;
        start        = 1'b0;
    endtask

    initial begin
        int lat;
        logic [38:0] bad_word;

        rst = 1'b1;
        start = 1'b0;
        bus.cpu_busy = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_waddr = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            golden[i] = encode(32'h1234_5678 ^ (32'h0101_0101 * i));
            mem[i] = golden[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({busy, done, bus.mem_rd_en, bus.mem_we, uncorr_flag}), 64'd0);
        check("rst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
        check("rst_addrs", 64'({bus.mem_addr, uncorr_addr}), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk) rst = 1'b0;

`ifdef SCRUB_CONTINUOUS_EN
        run_pass(-1, 0, -1, lat);
        check("cont_first_done_lat", 64'(lat), 64'd16);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!done && lat < 100);
        check("cont_period", 64'(lat), 64'd16);
        check("cont_busy_held", 64'(busy), 64'd1);
`else
        // Clean memory: no writes, 16-cycle pass.
        run_pass(-1, 0, -1, lat);
        check("clean_lat", 64'(lat), 64'd16);
        check("clean_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);

        // Single-bit error at a data position.
        mem[1] = golden[1] ^ (39'd1 << 6);
        sb.push_back({8'd1, golden[1]});
        run_pass(-1, 0, -1, lat);
        check("single_lat", 64'(lat), 64'd17);
        check("single_corr_cnt", 64'(corr_cnt), 64'd1);
        check("single_flag", 64'(uncorr_flag), 64'd0);
        check("single_mem_fixed", 64'(mem[1]), 64'(golden[1]));

        // Double-bit error: logged, never written.
        bad_word = golden[1] ^ (39'd1 << 5) ^ (39'd1 << 6);
        mem[1] = bad_word;
        run_pass(-1, 0, -1, lat);
        check("double_lat", 64'(lat), 64'd16);
        check("double_uncorr_cnt", 64'(uncorr_cnt), 64'd1);
        check("double_flag", 64'(uncorr_flag), 64'd1);
        check("double_addr", 64'(uncorr_addr), 64'd1);
        check("double_corr_cnt", 64'(corr_cnt), 64'd1);
        check("double_mem_kept", 64'(mem[1]), 64'(bad_word));
        mem[1] = golden[1];

        // CPU holds the port for the three cycles of the writeback.
        mem[2] = golden[2] ^ (39'd1 << 6);
        sb.push_back({8'd2, golden[2]});
        run_pass(11, 3, -1, lat);
        check("stall_lat", 64'(lat), 64'd20);
        check("stall_corr_cnt", 64'(corr_cnt), 64'd2);
        check("stall_mem_fixed", 64'(mem[2]), 64'(golden[2]));

        // Overall-parity error cancelled by a CPU write to the same address during CHECK.
        bad_word = golden[3] ^ 39'd1;
        mem[3] = bad_word;
        run_pass(-1, 0, 14, lat);
        check("cancel_lat", 64'(lat), 64'd17);
        check("cancel_corr_cnt", 64'(corr_cnt), 64'd2);
        check("cancel_mem_kept", 64'(mem[3]), 64'(bad_word));
        mem[3] = golden[3];

        // Reset in the middle of the READ of address 2, then rescan from 0.
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_addr", 64'(bus.mem_addr), 64'd2);
        check("mid_rd_en", 64'(bus.mem_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 64'({busy, done, bus.mem_rd_en, bus.mem_we, uncorr_flag}), 64'd0);
        check("mid_rst_cnts", 64'({corr_cnt, uncorr_cnt, bus.mem_addr, uncorr_addr}), 64'd0);
        @(negedge clk) rst = 1'b0;
        mem[0] = golden[0] ^ (39'd1 << 10);
        sb.push_back({8'd0, golden[0]});
        run_pass(-1, 0, -1, lat);
        check("rescan_lat", 64'(lat), 64'd17);
        check("rescan_corr_cnt", 64'(corr_cnt), 64'd1);
        check("rescan_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_scrubber.md
Name: ecc_scrubber

Overview:
- Background reader for the Hamming SECDED-protected data memory.
- Walks every address, decodes each 39-bit codeword, writes back corrected codewords for single-bit errors, and logs double-bit (uncorrectable) errors.
- Shares the memory port with the pipeline; the CPU always has priority.

Parameters:
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of words scrubbed per pass (addresses 0..DEPTH-1, DEPTH ≤ 2^ADDR_W).
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pass from address 0 when idle.
- cpu_busy  in  1  CPU owns the memory port this cycle; scrubber issues no access.
- cpu_we  in  1  CPU write strobe (snooped).
- cpu_waddr  in  ADDR_W  CPU write address (snooped).
- mem_rd_en  out  1  scrubber read request.
- mem_we  out  1  scrubber write request.
- mem_addr  out  ADDR_W  scrubber access address.
- mem_wdata  out  39  corrected codeword.
- mem_rdata  in  39  raw codeword; valid exactly 1 cycle after mem_rd_en.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at end of pass.
- corr_cnt  out  CNT_W  corrected single-bit errors, saturating.
- uncorr_cnt  out  CNT_W  detected double-bit errors, saturating.
- uncorr_flag  out  1  sticky; set on first uncorrectable error.
- uncorr_addr  out  ADDR_W  address of the most recent uncorrectable error.

Behaviour:
- Codeword layout:
  - bit 0 is overall parity (even parity over bits 0..38).
  - bits 1..38 are Hamming positions; check bits sit at 1, 2, 4, 8, 16, 32.
  - data bits fill the remaining positions in ascending order (data[0] at pos 3).
- Decode:
  - syndrome S (6b) = XOR of indices of set bits 1..38.
  - P = XOR of bits 0..38.
  - S=0, P=0: clean.
  - P=1, S=0: error in bit 0; correct by flipping bit 0.
  - P=1, 1≤S≤38: flip bit S.
  - P=1, S>38: uncorrectable.
  - S≠0, P=0: uncorrectable (double).
- FSM states and transitions:
  - IDLE → READ on start.
  - READ: when !cpu_busy, assert mem_rd_en with mem_addr=addr; → WAIT.
  - WAIT: capture mem_rdata into a register, regardless of cpu_busy; → CHECK.
  - CHECK: decode the captured word.
    - clean → NEXT.
    - correctable → WRITE.
    - uncorrectable → log; → NEXT.
  - WRITE: when !cpu_busy and not cancelled, assert mem_we with the corrected codeword at addr, increment corr_cnt; → NEXT.
  - NEXT: if addr==DEPTH-1, → DONE; else addr+1 → READ.
  - DONE: pulse done; → IDLE.
- Latency: clean word takes 4 cycles (READ, WAIT, CHECK, NEXT); a corrected word adds 1 cycle; each cpu_busy cycle in READ/WRITE adds 1 cycle.
- Stale-write guard: cpu_we=1 with cpu_waddr==addr in any cycle from READ issue through WRITE cancels the writeback.
  - The word is not counted as corrected; the scrubber proceeds to NEXT.
  - Uncorrectable logging is not cancelled.
- Uncorrectable log: uncorr_cnt+1 (saturating), uncorr_addr=addr, uncorr_flag=1.
- Counters saturate at 2^CNT_W-1 and are never cleared except by reset.
- start while busy is ignored.
- mem_rd_en and mem_we are never both high, and both are low whenever cpu_busy=1.
- Reset, at any time including mid-pass:
  - all outputs 0; FSM → IDLE; addr=0.
  - counters, flag and uncorr_addr cleared.
  - an in-flight read is discarded.

Optional Feature:
- Macro: SCRUB_CONTINUOUS_EN.
- Defined:
  - after DONE, the FSM returns to READ at address 0 with no start required.
  - done pulses once per pass; busy stays high.
  - start is ignored.
- Undefined: the block stops in IDLE after each pass and needs start for the next pass.

Test Plan:
- Clean memory (DEPTH=4, all valid codewords), start → no mem_we; done pulses 16 cycles after start; corr_cnt=0, uncorr_cnt=0.
- Flip bit 6 of the codeword at addr 1, start → one mem_we at addr 1 with the original codeword; corr_cnt=1; uncorr_flag=0.
- Flip bits 5 and 6 at addr 1 → no mem_we; uncorr_cnt=1, uncorr_flag=1, uncorr_addr=1.
- Flip bit 6 at addr 2, hold cpu_busy=1 during WRITE for 3 cycles → write is delayed 3 cycles then occurs; no access while cpu_busy is high.
- Flip bit 0 at addr 3, and pulse cpu_we with cpu_waddr=3 during CHECK → no writeback; corr_cnt unchanged.
- Assert rst mid-pass at addr 2 → all outputs 0 within the same cycle; a later start rescans from addr 0. With SCRUB_CONTINUOUS_EN: done pulses every 16 cycles on clean memory.
